// File: rtl/midi_rx_msg_if.sv
// Output bundle of the MIDI receiver: byte strobe, parser state, message/realtime/error events.
// Latency: n/a (wires only).
// Backpressure: none; every strobe is a one-cycle pulse the consumer must catch.
//
// master : driven by midi_rx_msg
// slave  : consumer side
interface midi_rx_msg_if;
   logic       byteready;
   logic [7:0] databyte;
   logic [7:0] cur_status;
   logic [7:0] midi_bytes;
   logic       msg_valid;
   logic [7:0] msg_status;
   logic [7:0] msg_data1;
   logic [7:0] msg_data2;
   logic       rt_valid;
   logic [7:0] rt_byte;
   logic       frame_err;
   logic       sysex_active;

   modport master (
      output byteready, databyte, cur_status, midi_bytes,
             msg_valid, msg_status, msg_data1, msg_data2,
             rt_valid, rt_byte, frame_err, sysex_active
   );

   modport slave (
      input  byteready, databyte, cur_status, midi_bytes,
             msg_valid, msg_status, msg_data1, msg_data2,
             rt_valid, rt_byte, frame_err, sysex_active
   );
endinterface

// File: rtl/midi_rx_msg.sv
// MIDI UART receiver (OVS oversampling, 3-sample majority) with running-status channel message parser.
// Latency: byteready 1 clk after stop-bit majority sample; msg_valid 1 clk after byteready.
// Backpressure: none; byteready/msg_valid/rt_valid/frame_err are single-cycle pulses.
//
// Ports: CLOCK_25 clock, iRST_N async active-low reset, midi_rxd raw serial line (idle high),
//        initial_reset sync clear/hold, bus (master) carries all receiver and parser outputs.
module midi_rx_msg #(
   parameter int CLK_HZ = 25000000,
   parameter int BAUD   = 31250,
   parameter int OVS    = 16
) (
   input  logic          CLOCK_25,
   input  logic          iRST_N,
   input  logic          midi_rxd,
   input  logic          initial_reset,
   midi_rx_msg_if.master bus
);

   localparam int DIV = CLK_HZ / (BAUD * OVS);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVS);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVS - 1);
   localparam logic [SW-1:0] S_M0     = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_M1     = SW'(OVS / 2);
   localparam logic [SW-1:0] S_M2     = SW'(OVS / 2 + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state;
   logic          sync1, sync2, rx_prev;
   logic [DW-1:0] div_cnt;
   logic [SW-1:0] samp;
   logic [1:0]    ones;     // ones seen among the first two majority samples of this bit
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    data1;
   logic [1:0]    need;     // data bytes per message for the current channel status

   logic          rx, tick, maj;
   logic [7:0]    next_cnt;

   assign rx       = sync2;
   assign tick     = (div_cnt == DIV_LAST);
   // third sample is the live line value, so the majority is ready on the last sample tick
   assign maj      = (ones == 2'd2) || ((ones == 2'd1) && rx);
   assign next_cnt = bus.midi_bytes + 8'd1;

   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1            <= 1'b1;
         sync2            <= 1'b1;
         rx_prev          <= 1'b0;
         state            <= IDLE;
         div_cnt          <= '0;
         samp             <= '0;
         ones             <= '0;
         bit_cnt          <= '0;
         shreg            <= '0;
         data1            <= '0;
         need             <= '0;
         bus.byteready    <= 1'b0;
         bus.databyte     <= '0;
         bus.cur_status   <= '0;
         bus.midi_bytes   <= '0;
         bus.msg_valid    <= 1'b0;
         bus.msg_status   <= '0;
         bus.msg_data1    <= '0;
         bus.msg_data2    <= '0;
         bus.rt_valid     <= 1'b0;
         bus.rt_byte      <= '0;
         bus.frame_err    <= 1'b0;
         bus.sysex_active <= 1'b0;
      end else begin
         sync1   <= midi_rxd;
         sync2   <= sync1;
         rx_prev <= sync2;

         bus.byteready <= 1'b0;
         bus.msg_valid <= 1'b0;
         bus.rt_valid  <= 1'b0;
         bus.frame_err <= 1'b0;

         if (initial_reset) begin
            state            <= IDLE;
            div_cnt          <= '0;
            samp             <= '0;
            ones             <= '0;
            bit_cnt          <= '0;
            data1            <= '0;
            need             <= '0;
            bus.cur_status   <= '0;
            bus.midi_bytes   <= '0;
            bus.sysex_active <= 1'b0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            case (state)
               IDLE: begin
                  if (rx_prev && !rx) begin
                     state   <= START;
                     div_cnt <= '0;
                     samp    <= '0;
                     ones    <= '0;
                  end
               end

               START, DATA, STOP: begin
                  if (tick) begin
                     samp <= (samp == S_LAST) ? '0 : samp + 1'b1;
                     if (samp == S_M0 || samp == S_M1)
                        ones <= ones + {1'b0, rx};
                     if (samp == S_M2) begin
                        if (state == START && maj)
                           state <= IDLE;               // glitch, not a start bit
                        if (state == DATA)
                           shreg <= {maj, shreg[7:1]};
                        if (state == STOP) begin
                           if (maj) begin
                              // good stop: report now, do not wait for the bit to end
                              state         <= IDLE;
                              bus.byteready <= 1'b1;
                              bus.databyte  <= shreg;
                              bus.rt_valid  <= (shreg >= 8'hF8);
                              bus.rt_byte   <= shreg;
                           end else begin
                              state         <= BREAK;
                              samp          <= '0;
                              bus.frame_err <= 1'b1;
                           end
                        end
                     end
                     if (samp == S_LAST) begin
                        ones <= '0;
                        if (state == START) begin
                           state   <= DATA;
                           bit_cnt <= '0;
                        end
                        if (state == DATA) begin
                           bit_cnt <= bit_cnt + 1'b1;
                           if (bit_cnt == 3'd7)
                              state <= STOP;
                        end
                     end
                  end
               end

               BREAK: begin
                  // need one uninterrupted bit time of idle line before rearming
                  if (!rx) begin
                     div_cnt <= '0;
                     samp    <= '0;
                  end else if (tick) begin
                     if (samp == S_LAST) begin
                        state <= IDLE;
                        samp  <= '0;
                     end else begin
                        samp <= samp + 1'b1;
                     end
                  end
               end

               default: state <= IDLE;
            endcase

            // parser works on the byte presented in the byteready cycle
            if (bus.byteready) begin
               if (bus.databyte >= 8'hF8) begin
                  // realtime: already flagged, parser state untouched
               end else if (bus.databyte >= 8'hF1) begin
                  bus.cur_status   <= '0;
                  bus.midi_bytes   <= '0;
                  bus.sysex_active <= 1'b0;
               end else if (bus.databyte == 8'hF0) begin
                  bus.cur_status   <= 8'hF0;
                  bus.midi_bytes   <= '0;
                  bus.sysex_active <= 1'b1;
               end else if (bus.databyte[7]) begin
                  bus.cur_status   <= bus.databyte;
                  bus.midi_bytes   <= '0;
                  bus.sysex_active <= 1'b0;
                  need             <= (bus.databyte[7:5] == 3'b110) ? 2'd1 : 2'd2;
               end else if (bus.cur_status == 8'h00) begin
                  // stray data with no status: dropped
               end else if (bus.sysex_active) begin
                  if (bus.midi_bytes != 8'hFF)
                     bus.midi_bytes <= next_cnt;
               end else if (next_cnt == {6'd0, need}) begin
                  bus.msg_valid  <= 1'b1;
                  bus.msg_status <= bus.cur_status;
                  bus.msg_data1  <= (need == 2'd1) ? bus.databyte : data1;
                  bus.msg_data2  <= (need == 2'd1) ? 8'h00 : bus.databyte;
                  bus.midi_bytes <= '0;           // status kept for running status
               end else begin
                  data1          <= bus.databyte;
                  bus.midi_bytes <= next_cnt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_rx_msg.sv
module tb_midi_rx_msg;

   // 2.5 MHz / (31250*16) gives 5 clocks per tick, 80 clocks per bit
   localparam int BIT_CLK = 80;

   logic CLOCK_25 = 1'b0;
   logic iRST_N;
   logic midi_rxd;
   logic initial_reset;

   always #5 CLOCK_25 = ~CLOCK_25;

   midi_rx_msg_if bus ();

   midi_rx_msg #(.CLK_HZ(2500000), .BAUD(31250), .OVS(16)) dut (
      .CLOCK_25      (CLOCK_25),
      .iRST_N        (iRST_N),
      .midi_rxd      (midi_rxd),
      .initial_reset (initial_reset),
      .bus           (bus.master)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- output monitor ----------------
   int         br_cnt = 0, mv_cnt = 0, rt_cnt = 0, fe_cnt = 0, mv_orphan = 0;
   logic [7:0] br_byte = 0, br_rtb = 0, mv_s = 0, mv_d1 = 0, mv_d2 = 0;
   logic       br_rt = 0, br_prev = 0;

   always @(negedge CLOCK_25) begin
      if (bus.byteready) begin
         br_cnt++;
         br_byte = bus.databyte;
         br_rt   = bus.rt_valid;
         br_rtb  = bus.rt_byte;
      end
      if (bus.rt_valid) rt_cnt++;
      if (bus.msg_valid) begin
         mv_cnt++;
         mv_s  = bus.msg_status;
         mv_d1 = bus.msg_data1;
         mv_d2 = bus.msg_data2;
         if (!br_prev) mv_orphan++;
      end
      if (bus.frame_err) fe_cnt++;
      br_prev = bus.byteready;
   end

   // ---------------- message-level reference model ----------------
   logic [7:0] m_status = 0;
   logic       m_sysex  = 0;
   int         m_sx_count = 0;
   logic [7:0] m_data[$];
   logic       e_rt, e_msg;
   logic [7:0] e_s, e_d1, e_d2;

   function automatic int msg_len(input logic [7:0] s);
      return (s >= 8'hC0 && s <= 8'hDF) ? 1 : 2;
   endfunction

   function automatic int exp_count();
      return m_sysex ? m_sx_count : m_data.size();
   endfunction

   task automatic model_clear();
      m_status   = 0;
      m_sysex    = 0;
      m_sx_count = 0;
      m_data.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      e_rt  = 0;
      e_msg = 0;
      if (b >= 8'hF8) e_rt = 1;
      else if (b >= 8'hF1) model_clear();
      else if (b == 8'hF0) begin
         model_clear();
         m_status = 8'hF0;
         m_sysex  = 1;
      end else if (b >= 8'h80) begin
         model_clear();
         m_status = b;
      end else if (m_status == 0) begin
      end else if (m_sysex) begin
         if (m_sx_count < 255) m_sx_count++;
      end else begin
         m_data.push_back(b);
         if (m_data.size() == msg_len(m_status)) begin
            e_msg = 1;
            e_s   = m_status;
            e_d1  = m_data[0];
            e_d2  = (m_data.size() == 2) ? m_data[1] : 8'h00;
            m_data.delete();
         end
      end
   endtask

   // ---------------- line driver ----------------
   task automatic hold_bit(input logic v);
      midi_rxd = v;
      repeat (BIT_CLK) @(negedge CLOCK_25);
   endtask

   // rst_bit >= 0 pulses iRST_N in the middle of that data bit
   task automatic drive_byte(input logic [7:0] b, input logic stop, input int rst_bit);
      @(negedge CLOCK_25);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_bit) begin
            midi_rxd = b[i];
            repeat (BIT_CLK / 2) @(negedge CLOCK_25);
            iRST_N = 1'b0;
            #1;
            chk("rst_databyte", bus.databyte, 8'h00);
            chk("rst_cur_status", bus.cur_status, 8'h00);
            chk("rst_msg_status", bus.msg_status, 8'h00);
            chk("rst_midi_bytes", bus.midi_bytes, 8'h00);
            repeat (3) @(negedge CLOCK_25);
            iRST_N = 1'b1;
            repeat (BIT_CLK / 2 - 3) @(negedge CLOCK_25);
         end else begin
            hold_bit(b[i]);
         end
      end
      hold_bit(stop);
      midi_rxd = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      int b0, r0, m0, f0;
      b0 = br_cnt; r0 = rt_cnt; m0 = mv_cnt; f0 = fe_cnt;
      drive_byte(b, 1'b1, -1);
      model_byte(b);
      chk("byteready_cnt", br_cnt - b0, 1);
      chk("databyte", br_byte, b);
      chk("rt_in_br_cycle", br_rt, e_rt);
      chk("rt_cnt", rt_cnt - r0, e_rt);
      if (e_rt) chk("rt_byte", br_rtb, b);
      chk("msg_cnt", mv_cnt - m0, e_msg);
      if (e_msg) begin
         chk("msg_status", mv_s, e_s);
         chk("msg_data1", mv_d1, e_d1);
         chk("msg_data2", mv_d2, e_d2);
      end
      chk("frame_err_cnt", fe_cnt - f0, 0);
      chk("cur_status", bus.cur_status, m_status);
      chk("midi_bytes", bus.midi_bytes, exp_count());
      chk("sysex_active", bus.sysex_active, m_sysex);
      repeat ($urandom_range(0, 20)) @(negedge CLOCK_25);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, f0, m0;
      logic [7:0] rb;
      iRST_N        = 1'b0;
      midi_rxd      = 1'b1;
      initial_reset = 1'b0;
      repeat (5) @(negedge CLOCK_25);
      chk("reset_byteready", bus.byteready, 0);
      chk("reset_databyte", bus.databyte, 0);
      chk("reset_cur_status", bus.cur_status, 0);
      chk("reset_midi_bytes", bus.midi_bytes, 0);
      chk("reset_msg_valid", bus.msg_valid, 0);
      chk("reset_sysex", bus.sysex_active, 0);
      chk("reset_frame_err", bus.frame_err, 0);
      iRST_N = 1'b1;
      repeat (BIT_CLK) @(negedge CLOCK_25);

      // note on, running status, program change
      send(8'h90); send(8'h3C); send(8'h64);
      send(8'h3E); send(8'h00);
      send(8'hC5); send(8'h07);

      // realtime byte inside a message
      send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);

      // short low glitch must be rejected
      b0 = br_cnt; f0 = fe_cnt;
      @(negedge CLOCK_25);
      midi_rxd = 1'b0;
      repeat (BIT_CLK / 8) @(negedge CLOCK_25);
      midi_rxd = 1'b1;
      repeat (3 * BIT_CLK) @(negedge CLOCK_25);
      chk("glitch_byteready", br_cnt - b0, 0);
      chk("glitch_frame_err", fe_cnt - f0, 0);

      // framing error: byte dropped, parser untouched
      b0 = br_cnt; f0 = fe_cnt; m0 = mv_cnt;
      drive_byte(8'h3C, 1'b0, -1);
      repeat (2 * BIT_CLK) @(negedge CLOCK_25);
      chk("ferr_pulse", fe_cnt - f0, 1);
      chk("ferr_byteready", br_cnt - b0, 0);
      chk("ferr_msg", mv_cnt - m0, 0);
      chk("ferr_cur_status", bus.cur_status, m_status);
      send(8'h3C); send(8'h64);

      // sysex
      send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7);

      // synchronous clear holds receiver idle
      send(8'h92); send(8'h40);
      @(negedge CLOCK_25);
      initial_reset = 1'b1;
      repeat (5) @(negedge CLOCK_25);
      chk("irst_cur_status", bus.cur_status, 0);
      chk("irst_midi_bytes", bus.midi_bytes, 0);
      b0 = br_cnt;
      drive_byte(8'h91, 1'b1, -1);
      chk("irst_hold_byteready", br_cnt - b0, 0);
      initial_reset = 1'b0;
      model_clear();
      repeat (BIT_CLK) @(negedge CLOCK_25);

      // async reset in the middle of a byte
      send(8'h90);
      b0 = br_cnt;
      drive_byte(8'hF0, 1'b1, 4);
      repeat (BIT_CLK) @(negedge CLOCK_25);
      chk("rst_partial_byteready", br_cnt - b0, 0);
      model_clear();
      send(8'h55);

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 9))
            0, 1:       rb = 8'($urandom_range(8'h80, 8'hEF));
            6:          rb = 8'($urandom_range(8'hF8, 8'hFF));
            7:          rb = 8'hF0;
            8:          rb = 8'($urandom_range(8'hF1, 8'hF7));
            default:    rb = 8'($urandom_range(0, 8'h7F));
         endcase
         send(rb);
      end

      chk("msg_after_byteready", mv_orphan, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
